// File: rtl/mux_select_sequencer_if.sv
// Handshake/status bundle between the mux select sequencer and its controller.
interface mux_select_sequencer_if #(
    parameter int DWELL_W = 4
);
    logic               start;
    logic               stop;
    logic [3:0]         ch_en;
    logic [DWELL_W-1:0] dwell;
    logic               cont;
    logic               hold;
    logic               s1;
    logic               s0;
    logic               slot_valid;
    logic               slot_first;
    logic               frame_done;
    logic               busy;

    modport slave (
        input  start, stop, ch_en, dwell, cont, hold,
        output s1, s0, slot_valid, slot_first, frame_done, busy
    );

    modport master (
        output start, stop, ch_en, dwell, cont, hold,
        input  s1, s0, slot_valid, slot_first, frame_done, busy
    );
endinterface

// File: rtl/mux_select_sequencer.sv
// Time-division scanner driving the 4:1 mux select lines.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | select parked at 0, waiting for start with a non-zero mask
//   S_RUN  | stepping through enabled channels, dwell_q+1 cycles each
module mux_select_sequencer #(
    parameter int DWELL_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    mux_select_sequencer_if.slave   bus
);
    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             r_state;
    logic [1:0]         r_sel;
    logic [DWELL_W-1:0] r_cnt;
    logic [3:0]         r_en_q;
    logic [DWELL_W-1:0] r_dwell_q;
    logic               r_cont_q;
    logic               r_slot_valid;
    logic               r_slot_first;
    logic               r_frame_done;
    logic               r_busy;

    logic               w_has_next;
    logic [1:0]         w_next_sel;
    logic [1:0]         w_start_sel;
    logic [1:0]         w_wrap_sel;

    function automatic logic [1:0] lowest_set(input logic [3:0] mask);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    assign w_start_sel = lowest_set(bus.ch_en);
    assign w_wrap_sel  = lowest_set(r_en_q);

    // Nearest enabled channel above the current one; descending scan so the closest wins.
    always_comb begin
        w_has_next = 1'b0;
        w_next_sel = r_sel;
        for (int i = 3; i >= 0; i--) begin
            if (i > int'(r_sel) && r_en_q[i]) begin
                w_has_next = 1'b1;
                w_next_sel = 2'(i);
            end
        end
    end

    // Sequencer FSM with all status outputs registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_sel        <= 2'd0;
            r_cnt        <= '0;
            r_en_q       <= 4'd0;
            r_dwell_q    <= '0;
            r_cont_q     <= 1'b0;
            r_slot_valid <= 1'b0;
            r_slot_first <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_slot_first <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start && (bus.ch_en != 4'd0)) begin
                        r_state      <= S_RUN;
                        r_en_q       <= bus.ch_en;
                        r_dwell_q    <= bus.dwell;
                        r_cont_q     <= bus.cont;
                        r_sel        <= w_start_sel;
                        r_cnt        <= '0;
                        r_slot_valid <= 1'b1;
                        r_slot_first <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (bus.stop) r_cont_q <= 1'b0;
                    if (!bus.hold) begin
                        if (r_cnt != r_dwell_q) begin
                            r_cnt <= r_cnt + DWELL_W'(1);
                        end else begin
                            r_cnt <= '0;
                            if (w_has_next) begin
                                r_sel        <= w_next_sel;
                                r_slot_first <= 1'b1;
                            end else begin
                                r_frame_done <= 1'b1;
                                // A stop seen on the final cycle still ends the scan here.
                                if (r_cont_q && !bus.stop) begin
                                    r_sel        <= w_wrap_sel;
                                    r_slot_first <= 1'b1;
                                end else begin
                                    r_state      <= S_IDLE;
                                    r_sel        <= 2'd0;
                                    r_slot_valid <= 1'b0;
                                    r_busy       <= 1'b0;
                                end
                            end
                        end
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_sel        <= 2'd0;
                    r_cnt        <= '0;
                    r_slot_valid <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s1         = r_sel[1];
    assign bus.s0         = r_sel[0];
    assign bus.slot_valid = r_slot_valid;
    assign bus.slot_first = r_slot_first;
    assign bus.frame_done = r_frame_done;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_mux_select_sequencer.sv
// Bench for the mux select sequencer: directed table, corner sequences and random traffic.
module tb_mux_select_sequencer;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mux_select_sequencer_if #(.DWELL_W(DW)) bus ();
    mux_select_sequencer #(.DWELL_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: position in the frame is a count of unheld cycles,
    // the channel is that count divided by the slot length.
    bit m_run = 0, m_cont = 0, m_first = 0, m_fd = 0;
    int m_list[4];
    int m_n = 0, m_d = 0, m_k = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run = 0; m_cont = 0; m_first = 0; m_fd = 0;
            m_n = 0; m_d = 0; m_k = 0;
        end else if (!m_run) begin
            m_fd = 0; m_first = 0;
            if (bus.start && bus.ch_en != 4'd0) begin
                m_n = 0;
                for (int i = 0; i < 4; i++)
                    if (bus.ch_en[i]) begin m_list[m_n] = i; m_n++; end
                m_d = int'(bus.dwell);
                m_cont = bus.cont;
                m_k = 0; m_run = 1; m_first = 1;
            end
        end else begin
            m_fd = 0; m_first = 0;
            if (bus.stop) m_cont = 0;
            if (!bus.hold) begin
                if (m_k + 1 == m_n * (m_d + 1)) begin
                    m_fd = 1;
                    if (m_cont) begin m_k = 0; m_first = 1; end
                    else m_run = 0;
                end else begin
                    m_k++;
                    m_first = (m_k % (m_d + 1) == 0);
                end
            end
        end
    end

    function automatic logic [5:0] model_outs();
        logic [1:0] s;
        s = m_run ? 2'(m_list[m_k / (m_d + 1)]) : 2'd0;
        return {s, m_run, m_first, m_fd, m_run};
    endfunction

    function automatic logic [5:0] dut_outs();
        return {bus.s1, bus.s0, bus.slot_valid, bus.slot_first, bus.frame_done, bus.busy};
    endfunction

    always @(negedge clk) if (chk_on) chk("cycle_vs_model", 32'(dut_outs()), 32'(model_outs()));

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic int sel();
        return int'({bus.s1, bus.s0});
    endfunction

    task automatic wait_idle();
        int g = 0;
        while (bus.busy && g < 200) begin step(); g++; end
        chk("wait_idle", 32'(bus.busy), 0);
        step();
    endtask

    task automatic start_scan(input logic [3:0] en, input logic [3:0] dw, input logic c);
        bus.ch_en = en; bus.dwell = dw; bus.cont = c; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    typedef struct {
        logic [3:0] en;
        logic [3:0] dw;
        int         exp_len;
        int         exp_first;
        int         exp_last;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int len, fsel, lsel, guard, fdc, c2;
        bit held;
        int sels[4];

        vecs[0] = '{4'b1010, 4'd2, 6, 1, 3};
        vecs[1] = '{4'b0001, 4'd0, 1, 0, 0};
        vecs[2] = '{4'b1111, 4'd1, 8, 0, 3};
        vecs[3] = '{4'b0110, 4'd3, 8, 1, 2};
        vecs[4] = '{4'b1000, 4'd5, 6, 3, 3};
        vecs[5] = '{4'b0101, 4'd0, 2, 0, 2};

        bus.start = 0; bus.stop = 0; bus.hold = 0;
        bus.ch_en = 0; bus.dwell = 0; bus.cont = 0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        chk_on = 1'b1;
        chk("reset_outs", 32'(dut_outs()), 0);

        // start with an empty mask is ignored
        start_scan(4'b0000, 4'd1, 1'b1);
        chk("empty_start_busy", 32'(bus.busy), 0);
        chk("empty_start_valid", 32'(bus.slot_valid), 0);

        // single-frame table
        for (int v = 0; v < 6; v++) begin
            start_scan(vecs[v].en, vecs[v].dw, 1'b0);
            len = 0; fsel = -1; lsel = -1; guard = 0;
            while (!bus.frame_done && guard < 200) begin
                if (bus.busy) begin
                    if (fsel < 0) fsel = sel();
                    lsel = sel();
                    len++;
                end
                step(); guard++;
            end
            chk("tbl_len", 32'(len), 32'(vecs[v].exp_len));
            chk("tbl_first_sel", 32'(fsel), 32'(vecs[v].exp_first));
            chk("tbl_last_sel", 32'(lsel), 32'(vecs[v].exp_last));
            chk("tbl_idle_at_done", 32'(bus.busy), 0);
            step();
        end

        // sparse mask, exact per-cycle timeline
        start_scan(4'b1010, 4'd2, 1'b0);
        for (int i = 0; i < 7; i++) begin
            if (i < 6) begin
                chk("sparse_sel", 32'(sel()), (i < 3) ? 1 : 3);
                chk("sparse_first", 32'(bus.slot_first), (i == 0 || i == 3) ? 1 : 0);
            end else begin
                chk("sparse_done", 32'(bus.frame_done), 1);
                chk("sparse_busy", 32'(bus.busy), 0);
            end
            step();
        end

        // start and ch_en changes during RUN are ignored
        start_scan(4'b1111, 4'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            sels[i] = sel();
            if (i == 0) begin
                bus.start = 1; bus.ch_en = 4'b0001; bus.dwell = 4'd7; bus.cont = 1;
            end
            step();
            bus.start = 0;
        end
        for (int i = 0; i < 4; i++) chk("ignored_start_sel", 32'(sels[i]), 32'(i));
        chk("ignored_start_done", 32'(bus.frame_done), 1);
        wait_idle();

        // continuous with stop: exactly one more frame_done
        start_scan(4'b0101, 4'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("cont_sel", 32'(sel()), 32'((i % 2) * 2));
            step();
        end
        chk("cont_sel_before_stop", 32'(sel()), 0);
        bus.stop = 1; step(); bus.stop = 0;
        fdc = 0;
        for (int i = 0; i < 8; i++) begin
            fdc += int'(bus.frame_done);
            step();
        end
        chk("stop_done_pulses", 32'(fdc), 1);
        chk("stop_busy", 32'(bus.busy), 0);

        // hold stretches the sel=10 slot to 5 cycles, frame to 11
        start_scan(4'b1111, 4'd1, 1'b0);
        len = 0; c2 = 0; held = 0; guard = 0;
        while (!bus.frame_done && guard < 200) begin
            if (bus.busy) begin
                len++;
                if (sel() == 2) c2++;
            end
            if (sel() == 2 && !held) begin
                bus.hold = 1;
                repeat (3) step();
                bus.hold = 0;
                held = 1; len += 3; c2 += 3;
            end
            step(); guard++;
        end
        chk("hold_frame_len", 32'(len), 11);
        chk("hold_slot_len", 32'(c2), 5);
        step();

        // single channel, continuous
        start_scan(4'b1000, 4'd2, 1'b1);
        for (int i = 0; i < 9; i++) begin
            chk("single_sel", 32'(sel()), 3);
            chk("single_first", 32'(bus.slot_first), (i % 3 == 0) ? 1 : 0);
            chk("single_done", 32'(bus.frame_done), (i % 3 == 0 && i > 0) ? 1 : 0);
            step();
        end
        bus.stop = 1; step(); bus.stop = 0;
        wait_idle();

        // back-to-back start in the frame_done cycle
        start_scan(4'b0011, 4'd0, 1'b0);
        step(); step();
        chk("b2b_done", 32'(bus.frame_done), 1);
        chk("b2b_idle", 32'(bus.busy), 0);
        start_scan(4'b0100, 4'd0, 1'b0);
        chk("b2b_busy", 32'(bus.busy), 1);
        chk("b2b_sel", 32'(sel()), 2);
        chk("b2b_first", 32'(bus.slot_first), 1);
        wait_idle();

        // asynchronous reset mid-run
        start_scan(4'b1111, 4'd3, 1'b1);
        repeat (5) step();
        #1 rst = 1'b1;
        #1 chk("rst_immediate", 32'(dut_outs()), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (5) step();
        chk("rst_no_activity", 32'(bus.busy), 0);

        // random traffic against the model
        for (int c = 0; c < 600; c++) begin
            bus.start = ($urandom_range(0, 7) == 0);
            bus.stop  = ($urandom_range(0, 15) == 0);
            bus.hold  = ($urandom_range(0, 3) == 0);
            bus.ch_en = 4'($urandom_range(0, 15));
            bus.dwell = 4'($urandom_range(0, 3));
            bus.cont  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) rst = 1'b1;
            step();
            rst = 1'b0;
        end
        bus.start = 0; bus.stop = 1; bus.hold = 0;
        repeat (40) step();
        bus.stop = 0;
        chk("final_idle", 32'(bus.busy), 0);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
